spike_dispatch_scheduler: RTL
=============================

Name: spike_dispatch_scheduler

Overview:
- Timestep scheduler that sequences the synaptic processing unit (SPU).
- On each timestep start it latches the neuron spike vector and scans it in ascending index order.
- Each spiking neuron's tag is pushed into an internal source-tag FIFO; the SPU dequeues tags from that FIFO.
- When the scan is finished, the FIFO is drained and the SPU has been idle for a settle window, it pulses step_done so the neuron update stage can proceed.

Parameters:
- numneurons, 2, number of neurons; width of spike_vec.
- tagbits, 1, neuron tag width; ceil(log2(numneurons)), minimum 1.
- fifodepth, 4, source-tag FIFO entries; power of two, minimum 2.
- ptrbits, 2, log2(fifodepth).
- settle, 3, number of consecutive idle cycles required before step_done.

Ports:
- clk  input  1  rising-edge clock.
- asyn_reset  input  1  synchronous active-high reset, sampled on the clk rising edge only.
- start  input  1  begin timestep; honoured only in IDLE.
- spike_vec  input  numneurons  spike flags; bit i = neuron i spiked.
- spu_req_deq  input  1  SPU pops the FIFO head.
- spu_busy  input  1  SPU busy flag.
- fifo_empty  output  1  FIFO holds no tags.
- src_tag_out  output  tagbits  FIFO head tag.
- busy  output  1  scheduler is not in IDLE.
- step_done  output  1  one-cycle pulse marking the end of the timestep.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (asyn_reset=1 at a clk edge, in any state, including mid-scan or mid-drain):
  - state=IDLE; FIFO count, read pointer and write pointer = 0; pending=0; scan_idx=0; settle counter=0.
  - Outputs: fifo_empty=1, src_tag_out=0, busy=0, step_done=0, overflow=0.
  - Reset has priority over every other input.
- States: IDLE, SCAN, DRAIN, DONE. busy=1 in every state except IDLE.
- IDLE:
  - start=1: pending<=spike_vec; scan_idx<=0; go to SCAN.
  - Otherwise stay in IDLE. start is ignored in all other states.
- SCAN: one index examined per cycle.
  - pending[scan_idx]=1 and FIFO not full: push scan_idx, clear that pending bit, advance scan_idx.
  - pending[scan_idx]=1 and FIFO full: stall; scan_idx holds.
  - pending[scan_idx]=0: advance scan_idx.
  - After index numneurons-1 is resolved: go to DRAIN and clear the settle counter.
  - An unstalled scan lasts exactly numneurons cycles.
- DRAIN:
  - Settle counter increments each cycle that fifo_empty=1 and spu_busy=0; it clears to 0 on any other cycle.
  - counter==settle-1 with the condition still true: go to DONE.
  - The settle window covers the SPU's two-cycle lag between the FIFO going non-empty and its busy flag rising.
- DONE: step_done=1 for exactly this one cycle; next state IDLE.
- FIFO:
  - Circular buffer; pointers wrap modulo fifodepth.
  - fifo_empty = (count==0).
  - src_tag_out = mem[rd_ptr] when count>0, else 0.
  - Pop: spu_req_deq=1 with count>0. A pop while empty is ignored; no pointer change.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - Push into a full FIFO cannot occur because SCAN stalls. A simultaneous pop does not free a slot until the next cycle.
- Latency: a tag pushed at edge N is visible on src_tag_out/fifo_empty after edge N.
- overflow: set if a push is ever attempted while count==fifodepth. This is a defensive assertion; it is cleared only by reset.
- spike_vec changes after start do not affect the timestep in progress.

Test Plan:
1. Reset then idle: hold asyn_reset 2 cycles, then start=0 for 5 cycles -> fifo_empty=1, busy=0, step_done=0, src_tag_out=0 throughout.
2. Basic dispatch (numneurons=4, tagbits=2, fifodepth=4): start with spike_vec=4'b1010, no pops -> tags 1 then 3 pushed on SCAN cycles 2 and 4; src_tag_out=1; stays in DRAIN while not empty.
3. Pop and done: continue scenario 2, pulse spu_req_deq twice with spu_busy=0 -> src_tag_out 1 then 3, then fifo_empty=1; step_done pulses exactly once, 3 cycles after empty; busy=0 on the following cycle.
4. Full stall (fifodepth=2): spike_vec=4'b1111, no pops -> scan stalls at index 2 with count=2. Then one pop per 2 cycles -> tags emitted in order 0,1,2,3; overflow stays 0.
5. Settle guard: FIFO empty but spu_busy=1 for 10 cycles, then 0 -> step_done pulses exactly 3 cycles after spu_busy falls, not earlier. A one-cycle spu_busy glitch during the window restarts the count.
6. Reset mid-op and ignored start: start with spike_vec=4'b0111, assert asyn_reset during SCAN -> next cycle busy=0, fifo_empty=1, no step_done. Separately, start asserted during DRAIN is ignored and pending is unchanged.

Source files
------------

// File: rtl/spike_dispatch_scheduler_if.sv
// Scheduler <-> SPU/timestep-controller handshake bundle.
// master drives timestep start, spike flags and SPU pop/busy; slave is the scheduler.
interface spike_dispatch_scheduler_if #(
  parameter int numneurons = 2,
  parameter int tagbits    = 1
);
  logic                  start;
  logic [numneurons-1:0] spike_vec;
  logic                  spu_req_deq;
  logic                  spu_busy;
  logic                  fifo_empty;
  logic [tagbits-1:0]    src_tag_out;
  logic                  busy;
  logic                  step_done;
  logic                  overflow;

  modport master (
    output start, spike_vec, spu_req_deq, spu_busy,
    input  fifo_empty, src_tag_out, busy, step_done, overflow
  );

  modport slave (
    input  start, spike_vec, spu_req_deq, spu_busy,
    output fifo_empty, src_tag_out, busy, step_done, overflow
  );
endinterface

// File: rtl/spike_dispatch_scheduler.sv
// Timestep scheduler: scans latched spikes into a tag FIFO for the SPU, one index per cycle, push visible next cycle.
// Scan stalls while the FIFO is full; step_done pulses after drain plus a settle window of SPU idle cycles.
module spike_dispatch_scheduler #(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int fifodepth  = 4,
  parameter int ptrbits    = 2,
  parameter int settle     = 3
) (
  input logic                       clk,
  input logic                       asyn_reset,
  spike_dispatch_scheduler_if.slave sif
);
  localparam int cntbits = $clog2(settle + 1);
  localparam logic [tagbits-1:0] last_idx    = tagbits'(numneurons - 1);
  localparam logic [ptrbits:0]   full_cnt    = (ptrbits + 1)'(fifodepth);
  localparam logic [cntbits-1:0] settle_last = cntbits'(settle - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [numneurons-1:0] pending;
  logic [tagbits-1:0]    scan_idx;
  logic [tagbits-1:0]    mem [fifodepth];
  logic [ptrbits-1:0]    rd_ptr;
  logic [ptrbits-1:0]    wr_ptr;
  logic [ptrbits:0]      count;
  logic [cntbits-1:0]    settle_cnt;
  logic                  overflow_q;

  logic fifo_full;
  logic cur_pend;
  logic push;
  logic pop;
  logic scan_adv;
  logic quiet;
  logic settle_hit;

  always_comb begin
    fifo_full  = (count == full_cnt);
    cur_pend   = pending[scan_idx];
    push       = (state == SCAN) && cur_pend && !fifo_full;
    pop        = sif.spu_req_deq && (count != '0);
    scan_adv   = (state == SCAN) && (!cur_pend || !fifo_full);
    quiet      = (count == '0) && !sif.spu_busy;
    settle_hit = quiet && (settle_cnt == settle_last);
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sif.start) state_nxt = SCAN;
      SCAN:    if (scan_adv && (scan_idx == last_idx)) state_nxt = DRAIN;
      DRAIN:   if (settle_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sif.busy        = (state != IDLE);
    sif.step_done   = (state == DONE);
    sif.fifo_empty  = (count == '0);
    sif.src_tag_out = (count != '0) ? mem[rd_ptr] : '0;
    sif.overflow    = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      pending    <= '0;
      scan_idx   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      settle_cnt <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((state == IDLE) && sif.start) begin
        pending  <= sif.spike_vec;
        scan_idx <= '0;
      end else if (scan_adv) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if (push) begin
        pending[scan_idx] <= 1'b0;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Counter only runs in DRAIN, so it is already zero on entry from SCAN.
      settle_cnt <= ((state == DRAIN) && quiet && !settle_hit) ? settle_cnt + 1'b1 : '0;
      // Guard against a future change to the stall logic letting a push into a full FIFO.
      if (push && fifo_full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= scan_idx;
  end
endmodule
